// File: rtl/serial_addsub.sv
// Purpose: bit-serial two's-complement adder/subtractor, DIGIT bits per cycle over N = WIDTH/DIGIT cycles.
// Latency: en sampled at edge k -> busy for N cycles -> done pulse (with out/cout/ovf valid) at cycle k+N+1.
// Backpressure: none; en is ignored while busy, so a new start is accepted only in IDLE or DONE.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   s;
  logic             c_msb;
  logic [WIDTH-1:0] dig_ext;
  logic             start;
  logic             running;
  logic             last;

  assign start   = en && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign running = (state_q == S_RUN);
  assign last    = running && (count_q == LAST);

  // Digit adder; the carry into the digit MSB is recovered from sum^a^b so overflow needs no second adder.
  always_comb begin
    a_dig   = a_q[DIGIT-1:0];
    b_dig   = b_q[DIGIT-1:0];
    s       = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(carry_q);
    c_msb   = s[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    dig_ext = WIDTH'(s[DIGIT-1:0]);
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_RUN;
      S_RUN:   if (count_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = en ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load operands on start, shift one digit per RUN cycle, latch flags on the last digit.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    count_d = count_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (start) begin
      // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub;
      count_d = '0;
    end else if (running) begin
      // New digit enters at the MSB end so after N shifts the result is aligned.
      out_d   = (out_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = s[DIGIT];
      count_d = count_q + 1'b1;
      if (last) begin
        cout_d = s[DIGIT];
        ovf_d  = c_msb ^ s[DIGIT];
      end
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      count_q <= count_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule
